// File: rtl/ar_ordering_queue_if.sv
// -----------------------------------------------------------------------------
// ar_if : AR request channel bundle (valid/ready handshake plus payload).
//
// Signals:
//   valid  - request valid (sender -> receiver)
//   ready  - receiver can accept (receiver -> sender)
//   id     - transaction ID (original ID upstream, unique ID downstream)
//   addr   - start address
//   len    - burst length
//   size   - burst size
//   burst  - burst type
//   qos    - quality-of-service hint
//
// Modports:
//   sender   - drives valid and payload, samples ready
//   receiver - samples valid and payload, drives ready
// -----------------------------------------------------------------------------
interface ar_if #(
    parameter int ID_WIDTH    = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int LEN_WIDTH   = 8,
    parameter int SIZE_WIDTH  = 3,
    parameter int BURST_WIDTH = 2,
    parameter int QOS_WIDTH   = 4
);
    logic                   valid;
    logic                   ready;
    logic [ID_WIDTH-1:0]    id;
    logic [ADDR_WIDTH-1:0]  addr;
    logic [LEN_WIDTH-1:0]   len;
    logic [SIZE_WIDTH-1:0]  size;
    logic [BURST_WIDTH-1:0] burst;
    logic [QOS_WIDTH-1:0]   qos;

    modport sender   (output valid, id, addr, len, size, burst, qos, input  ready);
    modport receiver (input  valid, id, addr, len, size, burst, qos, output ready);
endinterface

// File: rtl/ar_ordering_queue.sv
// -----------------------------------------------------------------------------
// ar_ordering_queue : multi-entry AR ordering stage.
//
// Buffers up to DEPTH AR requests in arrival order, requests a unique ID (UID)
// for each entry from the tag-map allocator strictly in order, and forwards
// entries in order with the ID field replaced by the granted UID. Allocation
// runs ahead of the output, so it overlaps with downstream backpressure.
//
// Ports:
//   clk           - clock
//   rst           - asynchronous, active-high reset
//   ar_in         - upstream AR channel (receiver)
//   ar_out        - downstream AR channel (sender); id carries the UID
//   alloc_req     - request a UID for the oldest unallocated entry
//   alloc_gnt     - allocator grant; unique_id valid this cycle
//   alloc_in_id   - original ID of the oldest unallocated entry
//   unique_id     - granted UID
//   tag_map_full  - allocator has no free UIDs; blocks input only
//   occupancy     - number of entries held (0..DEPTH)
//
// Optional feature (macro AR_ORDQ_HWM_EN):
//   occ_hwm       - high-water mark of occupancy since reset / last clear
//   hwm_clr       - load occ_hwm with the current occupancy
//
// Entries move through three regions of a circular buffer, delimited by
// rd_ptr <= al_ptr <= wr_ptr (mod DEPTH):
//   [rd_ptr, al_ptr) allocated, waiting for the output handshake
//   [al_ptr, wr_ptr) waiting for a UID
// -----------------------------------------------------------------------------
module ar_ordering_queue #(
    parameter int ID_WIDTH    = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int LEN_WIDTH   = 8,
    parameter int SIZE_WIDTH  = 3,
    parameter int BURST_WIDTH = 2,
    parameter int QOS_WIDTH   = 4,
    parameter int DEPTH       = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    ar_if.receiver                       ar_in,
    ar_if.sender                         ar_out,
    output logic                         alloc_req,
    input  logic                         alloc_gnt,
    output logic [ID_WIDTH-1:0]          alloc_in_id,
    input  logic [ID_WIDTH-1:0]          unique_id,
    input  logic                         tag_map_full,
`ifdef AR_ORDQ_HWM_EN
    output logic [$clog2(DEPTH+1)-1:0]   occ_hwm,
    input  logic                         hwm_clr,
`endif
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    // Entry storage
    logic [ID_WIDTH-1:0]    mem_id    [DEPTH];
    logic [ADDR_WIDTH-1:0]  mem_addr  [DEPTH];
    logic [LEN_WIDTH-1:0]   mem_len   [DEPTH];
    logic [SIZE_WIDTH-1:0]  mem_size  [DEPTH];
    logic [BURST_WIDTH-1:0] mem_burst [DEPTH];
    logic [QOS_WIDTH-1:0]   mem_qos   [DEPTH];
    logic [ID_WIDTH-1:0]    mem_uid   [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] al_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] occ;     // total entries held
    logic [CW-1:0] unal;    // entries still waiting for a UID

    logic hs_in;
    logic hs_out;
    logic grant;

    // -------------------------------------------------------------------------
    // Handshakes and combinational outputs (all derived from registered state,
    // so there is no combinational path from ar_in to ar_out)
    // -------------------------------------------------------------------------
    // Ready is held low while rst is asserted so that nothing is accepted
    // during reset even though occ already reads 0. A slot freed by a pop
    // only becomes usable once occ has been updated, i.e. the next cycle.
    assign ar_in.ready = ~rst & (occ < DEPTH_C) & ~tag_map_full;
    assign hs_in       = ar_in.valid & ar_in.ready;

    assign alloc_req   = (unal != '0);
    assign alloc_in_id = mem_id[al_ptr];
    // A grant without a pending request is ignored.
    assign grant       = alloc_req & alloc_gnt;

    // occ != unal is the same as (occ - unal) != 0: at least one allocated entry.
    assign ar_out.valid = (occ != unal);
    assign ar_out.id    = mem_uid[rd_ptr];
    assign ar_out.addr  = mem_addr[rd_ptr];
    assign ar_out.len   = mem_len[rd_ptr];
    assign ar_out.size  = mem_size[rd_ptr];
    assign ar_out.burst = mem_burst[rd_ptr];
    assign ar_out.qos   = mem_qos[rd_ptr];
    assign hs_out       = ar_out.valid & ar_out.ready;

    assign occupancy = occ;

    // -------------------------------------------------------------------------
    // Storage. A push writes at wr_ptr, a grant writes the UID at al_ptr. They
    // never collide: al_ptr == wr_ptr with unal != 0 means the queue is full
    // of unallocated entries, and then ar_in.ready is low.
    // -------------------------------------------------------------------------
    // NOTE: the storage array is cleared on reset because the idle ar_out
    // payload and alloc_in_id are read straight from it and must be 0 after
    // reset; otherwise a memory would normally be left unreset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_id[i]    <= '0;
                mem_addr[i]  <= '0;
                mem_len[i]   <= '0;
                mem_size[i]  <= '0;
                mem_burst[i] <= '0;
                mem_qos[i]   <= '0;
                mem_uid[i]   <= '0;
            end
        end else begin
            if (hs_in) begin
                mem_id[wr_ptr]    <= ar_in.id;
                mem_addr[wr_ptr]  <= ar_in.addr;
                mem_len[wr_ptr]   <= ar_in.len;
                mem_size[wr_ptr]  <= ar_in.size;
                mem_burst[wr_ptr] <= ar_in.burst;
                mem_qos[wr_ptr]   <= ar_in.qos;
            end
            if (grant) begin
                mem_uid[al_ptr] <= unique_id;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Pointers and counters. DEPTH is a power of two, so the natural wrap of
    // a PW-bit pointer implements DEPTH-1 -> 0.
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the handshake signals, independent of
    // statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            al_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            unal   <= '0;
        end else begin
            if (hs_in)  wr_ptr <= wr_ptr + PTR_ONE;
            if (grant)  al_ptr <= al_ptr + PTR_ONE;
            if (hs_out) rd_ptr <= rd_ptr + PTR_ONE;

            // push and pop together leave occ unchanged
            case ({hs_in, hs_out})
                2'b10:   occ <= occ + CNT_ONE;
                2'b01:   occ <= occ - CNT_ONE;
                default: ;
            endcase

            // push and grant together leave unal unchanged
            case ({hs_in, grant})
                2'b10:   unal <= unal + CNT_ONE;
                2'b01:   unal <= unal - CNT_ONE;
                default: ;
            endcase
        end
    end

`ifdef AR_ORDQ_HWM_EN
    // High-water mark: follows occ one cycle late whenever occ exceeds it;
    // a clear reloads it with the current occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_hwm <= '0;
        end else if (hwm_clr) begin
            occ_hwm <= occ;
        end else if (occ > occ_hwm) begin
            occ_hwm <= occ;
        end
    end
`endif

endmodule

// File: tb/tb_ar_ordering_queue.sv
// -----------------------------------------------------------------------------
// tb_ar_ordering_queue : directed self-checking bench for ar_ordering_queue.
// Inputs are driven 1 ns after the rising edge, outputs checked 1 ns later,
// well clear of the next active edge.
// -----------------------------------------------------------------------------
module tb_ar_ordering_queue;

    localparam int IDW   = 32;
    localparam int AW    = 32;
    localparam int LW    = 8;
    localparam int SW    = 3;
    localparam int BW    = 2;
    localparam int QW    = 4;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH+1);

    logic           clk = 1'b0;
    logic           rst;
    logic           alloc_req;
    logic           alloc_gnt;
    logic [IDW-1:0] alloc_in_id;
    logic [IDW-1:0] unique_id;
    logic           tag_map_full;
    logic [CW-1:0]  occupancy;
`ifdef AR_ORDQ_HWM_EN
    logic [CW-1:0]  occ_hwm;
    logic           hwm_clr;
`endif

    int total = 0;
    int bad   = 0;

    ar_if #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .SIZE_WIDTH(SW),
            .BURST_WIDTH(BW), .QOS_WIDTH(QW)) ar_in_if ();
    ar_if #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .SIZE_WIDTH(SW),
            .BURST_WIDTH(BW), .QOS_WIDTH(QW)) ar_out_if ();

    ar_ordering_queue #(
        .ID_WIDTH(IDW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .SIZE_WIDTH(SW),
        .BURST_WIDTH(BW), .QOS_WIDTH(QW), .DEPTH(DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ar_in        (ar_in_if),
        .ar_out       (ar_out_if),
        .alloc_req    (alloc_req),
        .alloc_gnt    (alloc_gnt),
        .alloc_in_id  (alloc_in_id),
        .unique_id    (unique_id),
        .tag_map_full (tag_map_full),
`ifdef AR_ORDQ_HWM_EN
        .occ_hwm      (occ_hwm),
        .hwm_clr      (hwm_clr),
`endif
        .occupancy    (occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive_in(input logic v, input logic [IDW-1:0] id, input logic [AW-1:0] addr,
                            input logic [LW-1:0] len, input logic [QW-1:0] qos);
        ar_in_if.valid = v;
        ar_in_if.id    = id;
        ar_in_if.addr  = addr;
        ar_in_if.len   = len;
        ar_in_if.size  = 3'd2;
        ar_in_if.burst = 2'd1;
        ar_in_if.qos   = qos;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst             = 1'b1;
        alloc_gnt       = 1'b0;
        unique_id       = '0;
        tag_map_full    = 1'b0;
        ar_out_if.ready = 1'b0;
`ifdef AR_ORDQ_HWM_EN
        hwm_clr         = 1'b0;
`endif
        drive_in(1'b0, '0, '0, '0, '0);

        // ---------------- reset state ----------------
        #2;
        check("rst_in_ready",  ar_in_if.ready,  0);
        check("rst_out_valid", ar_out_if.valid, 0);
        check("rst_alloc_req", alloc_req,       0);
        check("rst_occupancy", occupancy,       0);
        check("rst_out_id",    ar_out_if.id,    0);
        check("rst_out_addr",  ar_out_if.addr,  0);
        cyc();
        cyc();
        rst = 1'b0;
        settle();
        check("post_rst_in_ready", ar_in_if.ready, 1);

        // ---------------- single request ----------------
        cyc();
        drive_in(1'b1, 32'h5, 32'h1000, 8'd3, 4'hA);
        settle();
        check("single_ready", ar_in_if.ready, 1);
        cyc();                                   // hs_in happened here
        drive_in(1'b0, '0, '0, '0, '0);
        settle();
        check("single_req",       alloc_req,       1);
        check("single_alloc_id",  alloc_in_id,     32'h5);
        check("single_valid_n1",  ar_out_if.valid, 0);
        check("single_occ_n1",    occupancy,       1);
        alloc_gnt = 1'b1;
        unique_id = 32'h21;
        cyc();
        alloc_gnt = 1'b0;
        settle();
        check("single_valid_n2",  ar_out_if.valid, 1);
        check("single_out_id",    ar_out_if.id,    32'h21);
        check("single_out_addr",  ar_out_if.addr,  32'h1000);
        check("single_out_len",   ar_out_if.len,   3);
        check("single_out_size",  ar_out_if.size,  2);
        check("single_out_burst", ar_out_if.burst, 1);
        check("single_out_qos",   ar_out_if.qos,   4'hA);
        check("single_req_done",  alloc_req,       0);
        ar_out_if.ready = 1'b1;
        cyc();
        ar_out_if.ready = 1'b0;
        settle();
        check("single_valid_end", ar_out_if.valid, 0);
        check("single_occ_end",   occupancy,       0);

        // ---------------- stray grant ignored ----------------
        alloc_gnt = 1'b1;
        unique_id = 32'hFF;
        cyc();
        alloc_gnt = 1'b0;
        settle();
        check("stray_gnt_req",   alloc_req,       0);
        check("stray_gnt_valid", ar_out_if.valid, 0);
        check("stray_gnt_occ",   occupancy,       0);

        // ---------------- fill and backpressure ----------------
        for (int i = 0; i < 8; i++) begin
            drive_in(1'b1, 32'(32'h10 + i), 32'(32'h100 + i), 8'(i), 4'h1);
            settle();
            check("fill_ready", ar_in_if.ready, 1);
            cyc();
        end
        drive_in(1'b1, 32'hEE, 32'hEEEE, 8'd0, 4'h0);   // must not be accepted
        settle();
        check("fill_occ8",     occupancy,       8);
        check("fill_ready0",   ar_in_if.ready,  0);
        check("fill_valid0",   ar_out_if.valid, 0);
        for (int i = 0; i < 8; i++) begin
            settle();
            check("fill_alloc_id", alloc_in_id, 32'(32'h10 + i));
            alloc_gnt = 1'b1;
            unique_id = 32'(32'h80 + i);
            cyc();
        end
        alloc_gnt = 1'b0;
        drive_in(1'b0, '0, '0, '0, '0);
        settle();
        check("fill_req_done", alloc_req,       0);
        check("fill_valid1",   ar_out_if.valid, 1);
        check("fill_head_id",  ar_out_if.id,    32'h80);
        ar_out_if.ready = 1'b1;
        settle();
        check("fill_ready_on_pop", ar_in_if.ready, 0);
        cyc();
        ar_out_if.ready = 1'b0;
        settle();
        check("fill_ready_after_pop", ar_in_if.ready, 1);
        check("fill_occ7",            occupancy,      7);
        ar_out_if.ready = 1'b1;
        for (int k = 1; k < 8; k++) begin
            settle();
            check("fill_drain_id",   ar_out_if.id,   32'(32'h80 + k));
            check("fill_drain_addr", ar_out_if.addr, 32'(32'h100 + k));
            cyc();
        end
        ar_out_if.ready = 1'b0;
        settle();
        check("fill_occ0", occupancy, 0);

        // ---------------- order under delayed grant ----------------
        for (int i = 1; i <= 3; i++) begin
            drive_in(1'b1, 32'(i), 32'(i), 8'd0, 4'h2);
            cyc();
        end
        drive_in(1'b0, '0, '0, '0, '0);
        settle();
        check("dly_req",      alloc_req,       1);
        check("dly_alloc_1",  alloc_in_id,     1);
        check("dly_valid0",   ar_out_if.valid, 0);
        alloc_gnt = 1'b1;
        unique_id = 32'h40;
        cyc();
        unique_id = 32'h41;
        settle();
        check("dly_alloc_2",  alloc_in_id,     2);
        check("dly_valid1",   ar_out_if.valid, 1);
        cyc();
        unique_id = 32'h42;
        settle();
        check("dly_alloc_3",  alloc_in_id,     3);
        cyc();
        alloc_gnt = 1'b0;
        ar_out_if.ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            settle();
            check("dly_out_id",   ar_out_if.id,   32'(32'h40 + k));
            check("dly_out_addr", ar_out_if.addr, 32'(k + 1));
            cyc();
        end
        ar_out_if.ready = 1'b0;
        settle();
        check("dly_occ0", occupancy, 0);

        // ---------------- tag_map_full ----------------
        drive_in(1'b1, 32'h7, 32'h700, 8'd0, 4'h3);
        cyc();
        drive_in(1'b1, 32'h8, 32'h800, 8'd0, 4'h3);
        cyc();
        drive_in(1'b1, 32'h9, 32'h900, 8'd0, 4'h3);     // held off by tag_map_full
        tag_map_full = 1'b1;
        settle();
        check("tmf_ready0", ar_in_if.ready, 0);
        check("tmf_req1",   alloc_req,      1);
        alloc_gnt = 1'b1;
        unique_id = 32'h50;
        cyc();
        unique_id = 32'h51;
        settle();
        check("tmf_req_still", alloc_req,      1);
        check("tmf_ready_still", ar_in_if.ready, 0);
        cyc();
        alloc_gnt = 1'b0;
        ar_out_if.ready = 1'b1;
        settle();
        check("tmf_req_done", alloc_req,    0);
        check("tmf_out_id0",  ar_out_if.id, 32'h50);
        cyc();
        settle();
        check("tmf_out_id1",  ar_out_if.id, 32'h51);
        cyc();
        ar_out_if.ready = 1'b0;
        drive_in(1'b0, '0, '0, '0, '0);
        settle();
        check("tmf_occ0", occupancy, 0);
        tag_map_full = 1'b0;

        // ---------------- wrap with push/grant/pop every cycle ----------------
        ar_out_if.ready = 1'b1;
        for (int c = 0; c < 22; c++) begin
            if (c < 20) drive_in(1'b1, 32'(32'h30 + c), 32'(32'h2000 + c), 8'(c), 4'h4);
            else        drive_in(1'b0, '0, '0, '0, '0);
            alloc_gnt = (c >= 1 && c <= 20);
            unique_id = 32'(32'hA0 + c - 1);
            settle();
            if (c >= 1 && c <= 20) check("wrap_alloc_id", alloc_in_id, 32'(32'h30 + c - 1));
            if (c >= 2) begin
                check("wrap_valid",    ar_out_if.valid, 1);
                check("wrap_out_id",   ar_out_if.id,    32'(32'hA0 + c - 2));
                check("wrap_out_addr", ar_out_if.addr,  32'(32'h2000 + c - 2));
            end
            if (c >= 2 && c <= 20) check("wrap_occ", occupancy, 2);
            cyc();
        end
        alloc_gnt = 1'b0;
        ar_out_if.ready = 1'b0;
        settle();
        check("wrap_occ0",   occupancy,       0);
        check("wrap_valid0", ar_out_if.valid, 0);

        // ---------------- reset mid-operation ----------------
        for (int i = 0; i < 5; i++) begin
            drive_in(1'b1, 32'(32'h60 + i), 32'(32'h600 + i), 8'd0, 4'h5);
            cyc();
        end
        drive_in(1'b0, '0, '0, '0, '0);
        alloc_gnt = 1'b1;
        unique_id = 32'h70;
        cyc();
        unique_id = 32'h71;
        cyc();
        alloc_gnt = 1'b0;
        settle();
        check("mid_occ5",   occupancy,       5);
        check("mid_valid1", ar_out_if.valid, 1);
        check("mid_req1",   alloc_req,       1);
        #1;
        rst = 1'b1;                              // asserted between clock edges
        #1;
        check("mid_rst_valid", ar_out_if.valid, 0);
        check("mid_rst_req",   alloc_req,       0);
        check("mid_rst_occ",   occupancy,       0);
        check("mid_rst_ready", ar_in_if.ready,  0);
        check("mid_rst_id",    ar_out_if.id,    0);
        cyc();
        rst = 1'b0;
        drive_in(1'b1, 32'h9, 32'h3000, 8'd7, 4'h6);
        settle();
        check("after_rst_ready", ar_in_if.ready, 1);
        cyc();
        drive_in(1'b0, '0, '0, '0, '0);
        settle();
        check("after_rst_req",      alloc_req,   1);
        check("after_rst_alloc_id", alloc_in_id, 32'h9);
        check("after_rst_occ1",     occupancy,   1);
        alloc_gnt = 1'b1;
        unique_id = 32'h33;
        cyc();
        alloc_gnt = 1'b0;
        settle();
        check("after_rst_valid", ar_out_if.valid, 1);
        check("after_rst_id",    ar_out_if.id,    32'h33);
        check("after_rst_addr",  ar_out_if.addr,  32'h3000);
        check("after_rst_len",   ar_out_if.len,   7);
        ar_out_if.ready = 1'b1;
        cyc();
        ar_out_if.ready = 1'b0;
        settle();
        check("after_rst_occ0", occupancy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
